// File: rtl/axi4_mem_arbiter_pkg.sv
// Shared types and constants for the IFU/LSU AXI4 master-port arbiter.
// Read FSM encoding, AXI burst/response codes, default IDs and channel field widths.
package axi4_mem_arbiter_pkg;

    localparam int AXI_LEN_W   = 8;
    localparam int AXI_SIZE_W  = 3;
    localparam int AXI_BURST_W = 2;
    localparam int AXI_RESP_W  = 2;

    localparam logic [AXI_BURST_W-1:0] AXI_BURST_INCR  = 2'b01;
    localparam logic [AXI_RESP_W-1:0]  AXI_RESP_OKAY   = 2'b00;
    localparam logic [AXI_RESP_W-1:0]  AXI_RESP_SLVERR = 2'b10;

    localparam int IFU_ID_DEFAULT = 0;
    localparam int LSU_ID_DEFAULT = 1;

    typedef enum logic [2:0] {
        RD_IDLE   = 3'd0,
        RD_AR_IFU = 3'd1,
        RD_R_IFU  = 3'd2,
        RD_AR_LSU = 3'd3,
        RD_R_LSU  = 3'd4
    } rd_state_t;

    typedef enum logic {
        REQ_IFU = 1'b0,
        REQ_LSU = 1'b1
    } req_sel_t;

    function automatic logic is_ifu_state(input rd_state_t s);
        return (s == RD_AR_IFU) || (s == RD_R_IFU);
    endfunction

endpackage

// File: rtl/axi4_rd_mux.sv
// Combinational AR/R steering between the IFU and LSU read ports and the AXI4 master.
// The grant (sel_lsu) and phase come from the arbiter FSM; discard hides IFU beats and drains them.
module axi4_rd_mux
    import axi4_mem_arbiter_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 64,
    parameter int ID_W   = 4,
    parameter int IFU_ID = IFU_ID_DEFAULT,
    parameter int LSU_ID = LSU_ID_DEFAULT
) (
    input  logic                   ar_phase,
    input  logic                   r_phase,
    input  logic                   sel_lsu,
    input  logic                   discard,

    input  logic [ADDR_W-1:0]      ifu_araddr_i,
    input  logic [AXI_LEN_W-1:0]   ifu_arlen_i,
    input  logic [AXI_SIZE_W-1:0]  ifu_arsize_i,
    input  logic [AXI_BURST_W-1:0] ifu_arburst_i,
    output logic                   ifu_arready_o,
    input  logic [ADDR_W-1:0]      lsu_araddr_i,
    input  logic [AXI_LEN_W-1:0]   lsu_arlen_i,
    input  logic [AXI_SIZE_W-1:0]  lsu_arsize_i,
    input  logic [AXI_BURST_W-1:0] lsu_arburst_i,
    output logic                   lsu_arready_o,

    output logic                   ifu_rvalid_o,
    input  logic                   ifu_rready_i,
    output logic [DATA_W-1:0]      ifu_rdata_o,
    output logic [AXI_RESP_W-1:0]  ifu_rresp_o,
    output logic                   ifu_rlast_o,
    output logic                   lsu_rvalid_o,
    input  logic                   lsu_rready_i,
    output logic [DATA_W-1:0]      lsu_rdata_o,
    output logic [AXI_RESP_W-1:0]  lsu_rresp_o,
    output logic                   lsu_rlast_o,

    output logic                   io_master_arvalid,
    input  logic                   io_master_arready,
    output logic [ID_W-1:0]        io_master_arid,
    output logic [ADDR_W-1:0]      io_master_araddr,
    output logic [AXI_LEN_W-1:0]   io_master_arlen,
    output logic [AXI_SIZE_W-1:0]  io_master_arsize,
    output logic [AXI_BURST_W-1:0] io_master_arburst,
    input  logic                   io_master_rvalid,
    output logic                   io_master_rready,
    input  logic [DATA_W-1:0]      io_master_rdata,
    input  logic [AXI_RESP_W-1:0]  io_master_rresp,
    input  logic                   io_master_rlast
);

    always_comb begin
        io_master_arvalid = ar_phase;
        io_master_arid    = sel_lsu ? ID_W'(LSU_ID) : ID_W'(IFU_ID);
        io_master_araddr  = sel_lsu ? lsu_araddr_i  : ifu_araddr_i;
        io_master_arlen   = sel_lsu ? lsu_arlen_i   : ifu_arlen_i;
        io_master_arsize  = sel_lsu ? lsu_arsize_i  : ifu_arsize_i;
        io_master_arburst = sel_lsu ? lsu_arburst_i : ifu_arburst_i;

        ifu_arready_o = ar_phase & ~sel_lsu & io_master_arready;
        lsu_arready_o = ar_phase &  sel_lsu & io_master_arready;

        // A discarded IFU burst is invisible upstream and drained at full rate.
        ifu_rvalid_o     = r_phase & ~sel_lsu & ~discard & io_master_rvalid;
        lsu_rvalid_o     = r_phase &  sel_lsu & io_master_rvalid;
        io_master_rready = r_phase & (sel_lsu ? lsu_rready_i : (discard | ifu_rready_i));

        ifu_rdata_o = io_master_rdata;
        ifu_rresp_o = io_master_rresp;
        ifu_rlast_o = io_master_rlast;
        lsu_rdata_o = io_master_rdata;
        lsu_rresp_o = io_master_rresp;
        lsu_rlast_o = io_master_rlast;
    end

endmodule

// File: rtl/axi4_mem_arbiter.sv
// Shares one AXI4 master port between the IFU (read-only) and the LSU (read/write).
// Define ARB_RR_EN for round-robin tie-breaking; default is fixed LSU priority.
module axi4_mem_arbiter
    import axi4_mem_arbiter_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 64,
    parameter int ID_W   = 4,
    parameter int IFU_ID = IFU_ID_DEFAULT,
    parameter int LSU_ID = LSU_ID_DEFAULT
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   ifu_flush_i,

    input  logic                   ifu_arvalid_i,
    output logic                   ifu_arready_o,
    input  logic [ADDR_W-1:0]      ifu_araddr_i,
    input  logic [AXI_LEN_W-1:0]   ifu_arlen_i,
    input  logic [AXI_SIZE_W-1:0]  ifu_arsize_i,
    input  logic [AXI_BURST_W-1:0] ifu_arburst_i,
    output logic                   ifu_rvalid_o,
    input  logic                   ifu_rready_i,
    output logic [DATA_W-1:0]      ifu_rdata_o,
    output logic [AXI_RESP_W-1:0]  ifu_rresp_o,
    output logic                   ifu_rlast_o,

    input  logic                   lsu_arvalid_i,
    output logic                   lsu_arready_o,
    input  logic [ADDR_W-1:0]      lsu_araddr_i,
    input  logic [AXI_LEN_W-1:0]   lsu_arlen_i,
    input  logic [AXI_SIZE_W-1:0]  lsu_arsize_i,
    input  logic [AXI_BURST_W-1:0] lsu_arburst_i,
    output logic                   lsu_rvalid_o,
    input  logic                   lsu_rready_i,
    output logic [DATA_W-1:0]      lsu_rdata_o,
    output logic [AXI_RESP_W-1:0]  lsu_rresp_o,
    output logic                   lsu_rlast_o,

    input  logic                   lsu_awvalid_i,
    output logic                   lsu_awready_o,
    input  logic [ADDR_W-1:0]      lsu_awaddr_i,
    input  logic [AXI_LEN_W-1:0]   lsu_awlen_i,
    input  logic [AXI_SIZE_W-1:0]  lsu_awsize_i,
    input  logic [AXI_BURST_W-1:0] lsu_awburst_i,
    input  logic                   lsu_wvalid_i,
    output logic                   lsu_wready_o,
    input  logic [DATA_W-1:0]      lsu_wdata_i,
    input  logic [DATA_W/8-1:0]    lsu_wstrb_i,
    input  logic                   lsu_wlast_i,
    output logic                   lsu_bvalid_o,
    input  logic                   lsu_bready_i,
    output logic [AXI_RESP_W-1:0]  lsu_bresp_o,

    output logic                   io_master_arvalid,
    input  logic                   io_master_arready,
    output logic [ID_W-1:0]        io_master_arid,
    output logic [ADDR_W-1:0]      io_master_araddr,
    output logic [AXI_LEN_W-1:0]   io_master_arlen,
    output logic [AXI_SIZE_W-1:0]  io_master_arsize,
    output logic [AXI_BURST_W-1:0] io_master_arburst,
    input  logic                   io_master_rvalid,
    output logic                   io_master_rready,
    input  logic [ID_W-1:0]        io_master_rid,
    input  logic [DATA_W-1:0]      io_master_rdata,
    input  logic [AXI_RESP_W-1:0]  io_master_rresp,
    input  logic                   io_master_rlast,
    output logic                   io_master_awvalid,
    input  logic                   io_master_awready,
    output logic [ID_W-1:0]        io_master_awid,
    output logic [ADDR_W-1:0]      io_master_awaddr,
    output logic [AXI_LEN_W-1:0]   io_master_awlen,
    output logic [AXI_SIZE_W-1:0]  io_master_awsize,
    output logic [AXI_BURST_W-1:0] io_master_awburst,
    output logic                   io_master_wvalid,
    input  logic                   io_master_wready,
    output logic [DATA_W-1:0]      io_master_wdata,
    output logic [DATA_W/8-1:0]    io_master_wstrb,
    output logic                   io_master_wlast,
    input  logic                   io_master_bvalid,
    output logic                   io_master_bready,
    input  logic [ID_W-1:0]        io_master_bid,
    input  logic [AXI_RESP_W-1:0]  io_master_bresp,

    output logic                   burst_err_o,
    output logic [2:0]             rd_state_o
);

    rd_state_t              state_q, state_d;
    logic [AXI_LEN_W-1:0]   beat_cnt_q;
    logic                   discard_q;
    logic                   wr_pending_q;
    logic                   burst_err_q;

    logic ar_phase, r_phase, sel_lsu, discard;
    logic ar_hs, r_hs, r_last_hs, aw_hs, b_hs;
    logic lsu_rd_req, pick_lsu;
    logic unused_ids;

    // Read IDs are informational only: one read is outstanding at a time.
    assign unused_ids = ^{io_master_rid, io_master_bid};

    assign ar_phase  = (state_q == RD_AR_IFU) || (state_q == RD_AR_LSU);
    assign r_phase   = (state_q == RD_R_IFU)  || (state_q == RD_R_LSU);
    assign sel_lsu   = (state_q == RD_AR_LSU) || (state_q == RD_R_LSU);
    assign discard   = discard_q | (ifu_flush_i & is_ifu_state(state_q));

    assign ar_hs     = io_master_arvalid & io_master_arready;
    assign r_hs      = r_phase & io_master_rvalid & io_master_rready;
    assign r_last_hs = r_hs & io_master_rlast;
    assign aw_hs     = io_master_awvalid & io_master_awready;
    assign b_hs      = io_master_bvalid & io_master_bready;

    // An LSU read may not overtake its own unacknowledged write.
    assign lsu_rd_req = lsu_arvalid_i & ~wr_pending_q & ~aw_hs;

`ifdef ARB_RR_EN
    req_sel_t rr_ptr_q;

    assign pick_lsu = lsu_rd_req & (~ifu_arvalid_i | (rr_ptr_q == REQ_LSU));

    always_ff @(posedge clock) begin
        if (reset) begin
            rr_ptr_q <= REQ_IFU;
        end else if (r_last_hs) begin
            rr_ptr_q <= (state_q == RD_R_LSU) ? REQ_IFU : REQ_LSU;
        end
    end
`else
    assign pick_lsu = lsu_rd_req;
`endif

    always_comb begin
        state_d = state_q;
        case (state_q)
            RD_IDLE: begin
                if (pick_lsu)           state_d = RD_AR_LSU;
                else if (ifu_arvalid_i) state_d = RD_AR_IFU;
            end
            // arvalid is raised on entry, so a flush here is recorded as discard
            // rather than withdrawing the request.
            RD_AR_IFU: if (ar_hs)     state_d = RD_R_IFU;
            RD_R_IFU:  if (r_last_hs) state_d = RD_IDLE;
            RD_AR_LSU: if (ar_hs)     state_d = RD_R_LSU;
            RD_R_LSU:  if (r_last_hs) state_d = RD_IDLE;
            default:                  state_d = RD_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q      <= RD_IDLE;
            beat_cnt_q   <= '0;
            discard_q    <= 1'b0;
            wr_pending_q <= 1'b0;
            burst_err_q  <= 1'b0;
        end else begin
            state_q <= state_d;

            if (ar_hs) begin
                beat_cnt_q <= io_master_arlen;
            end else if (r_hs) begin
                if (io_master_rlast)       beat_cnt_q <= '0;
                else if (beat_cnt_q != '0) beat_cnt_q <= beat_cnt_q - 8'd1;
            end

            // Sticky: rlast early/late relative to the requested length.
            if (r_hs && ((io_master_rlast && beat_cnt_q != '0) ||
                         (!io_master_rlast && beat_cnt_q == '0))) begin
                burst_err_q <= 1'b1;
            end

            if (state_d == RD_IDLE)                          discard_q <= 1'b0;
            else if (ifu_flush_i && is_ifu_state(state_q))   discard_q <= 1'b1;

            if (aw_hs)     wr_pending_q <= 1'b1;
            else if (b_hs) wr_pending_q <= 1'b0;
        end
    end

    assign burst_err_o = burst_err_q;
    assign rd_state_o  = state_q;

    axi4_rd_mux #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W),
        .ID_W   (ID_W),
        .IFU_ID (IFU_ID),
        .LSU_ID (LSU_ID)
    ) u_rd_mux (
        .ar_phase          (ar_phase),
        .r_phase           (r_phase),
        .sel_lsu           (sel_lsu),
        .discard           (discard),
        .ifu_araddr_i      (ifu_araddr_i),
        .ifu_arlen_i       (ifu_arlen_i),
        .ifu_arsize_i      (ifu_arsize_i),
        .ifu_arburst_i     (ifu_arburst_i),
        .ifu_arready_o     (ifu_arready_o),
        .lsu_araddr_i      (lsu_araddr_i),
        .lsu_arlen_i       (lsu_arlen_i),
        .lsu_arsize_i      (lsu_arsize_i),
        .lsu_arburst_i     (lsu_arburst_i),
        .lsu_arready_o     (lsu_arready_o),
        .ifu_rvalid_o      (ifu_rvalid_o),
        .ifu_rready_i      (ifu_rready_i),
        .ifu_rdata_o       (ifu_rdata_o),
        .ifu_rresp_o       (ifu_rresp_o),
        .ifu_rlast_o       (ifu_rlast_o),
        .lsu_rvalid_o      (lsu_rvalid_o),
        .lsu_rready_i      (lsu_rready_i),
        .lsu_rdata_o       (lsu_rdata_o),
        .lsu_rresp_o       (lsu_rresp_o),
        .lsu_rlast_o       (lsu_rlast_o),
        .io_master_arvalid (io_master_arvalid),
        .io_master_arready (io_master_arready),
        .io_master_arid    (io_master_arid),
        .io_master_araddr  (io_master_araddr),
        .io_master_arlen   (io_master_arlen),
        .io_master_arsize  (io_master_arsize),
        .io_master_arburst (io_master_arburst),
        .io_master_rvalid  (io_master_rvalid),
        .io_master_rready  (io_master_rready),
        .io_master_rdata   (io_master_rdata),
        .io_master_rresp   (io_master_rresp),
        .io_master_rlast   (io_master_rlast)
    );

    // Write channels belong to the LSU alone and pass straight through.
    assign io_master_awvalid = lsu_awvalid_i;
    assign lsu_awready_o     = io_master_awready;
    assign io_master_awid    = ID_W'(LSU_ID);
    assign io_master_awaddr  = lsu_awaddr_i;
    assign io_master_awlen   = lsu_awlen_i;
    assign io_master_awsize  = lsu_awsize_i;
    assign io_master_awburst = lsu_awburst_i;
    assign io_master_wvalid  = lsu_wvalid_i;
    assign lsu_wready_o      = io_master_wready;
    assign io_master_wdata   = lsu_wdata_i;
    assign io_master_wstrb   = lsu_wstrb_i;
    assign io_master_wlast   = lsu_wlast_i;
    assign lsu_bvalid_o      = io_master_bvalid;
    assign io_master_bready  = lsu_bready_i;
    assign lsu_bresp_o       = io_master_bresp;

endmodule

// File: tb/tb_axi4_mem_arbiter.sv
// Directed bench for axi4_mem_arbiter: the bench plays both requesters and the downstream slave.
module tb_axi4_mem_arbiter;
    import axi4_mem_arbiter_pkg::*;

    logic        clock, reset, ifu_flush_i;
    logic        ifu_arvalid_i, ifu_arready_o;
    logic [31:0] ifu_araddr_i;
    logic [7:0]  ifu_arlen_i;
    logic [2:0]  ifu_arsize_i;
    logic [1:0]  ifu_arburst_i;
    logic        ifu_rvalid_o, ifu_rready_i, ifu_rlast_o;
    logic [63:0] ifu_rdata_o;
    logic [1:0]  ifu_rresp_o;
    logic        lsu_arvalid_i, lsu_arready_o;
    logic [31:0] lsu_araddr_i;
    logic [7:0]  lsu_arlen_i;
    logic [2:0]  lsu_arsize_i;
    logic [1:0]  lsu_arburst_i;
    logic        lsu_rvalid_o, lsu_rready_i, lsu_rlast_o;
    logic [63:0] lsu_rdata_o;
    logic [1:0]  lsu_rresp_o;
    logic        lsu_awvalid_i, lsu_awready_o;
    logic [31:0] lsu_awaddr_i;
    logic [7:0]  lsu_awlen_i;
    logic [2:0]  lsu_awsize_i;
    logic [1:0]  lsu_awburst_i;
    logic        lsu_wvalid_i, lsu_wready_o, lsu_wlast_i;
    logic [63:0] lsu_wdata_i;
    logic [7:0]  lsu_wstrb_i;
    logic        lsu_bvalid_o, lsu_bready_i;
    logic [1:0]  lsu_bresp_o;
    logic        io_master_arvalid, io_master_arready;
    logic [3:0]  io_master_arid;
    logic [31:0] io_master_araddr;
    logic [7:0]  io_master_arlen;
    logic [2:0]  io_master_arsize;
    logic [1:0]  io_master_arburst;
    logic        io_master_rvalid, io_master_rready, io_master_rlast;
    logic [3:0]  io_master_rid;
    logic [63:0] io_master_rdata;
    logic [1:0]  io_master_rresp;
    logic        io_master_awvalid, io_master_awready;
    logic [3:0]  io_master_awid;
    logic [31:0] io_master_awaddr;
    logic [7:0]  io_master_awlen;
    logic [2:0]  io_master_awsize;
    logic [1:0]  io_master_awburst;
    logic        io_master_wvalid, io_master_wready, io_master_wlast;
    logic [63:0] io_master_wdata;
    logic [7:0]  io_master_wstrb;
    logic        io_master_bvalid, io_master_bready;
    logic [3:0]  io_master_bid;
    logic [1:0]  io_master_bresp;
    logic        burst_err_o;
    logic [2:0]  rd_state_o;

    int n_checks = 0;
    int n_pass   = 0;

    axi4_mem_arbiter dut (
        .clock(clock), .reset(reset), .ifu_flush_i(ifu_flush_i),
        .ifu_arvalid_i(ifu_arvalid_i), .ifu_arready_o(ifu_arready_o), .ifu_araddr_i(ifu_araddr_i),
        .ifu_arlen_i(ifu_arlen_i), .ifu_arsize_i(ifu_arsize_i), .ifu_arburst_i(ifu_arburst_i),
        .ifu_rvalid_o(ifu_rvalid_o), .ifu_rready_i(ifu_rready_i), .ifu_rdata_o(ifu_rdata_o),
        .ifu_rresp_o(ifu_rresp_o), .ifu_rlast_o(ifu_rlast_o),
        .lsu_arvalid_i(lsu_arvalid_i), .lsu_arready_o(lsu_arready_o), .lsu_araddr_i(lsu_araddr_i),
        .lsu_arlen_i(lsu_arlen_i), .lsu_arsize_i(lsu_arsize_i), .lsu_arburst_i(lsu_arburst_i),
        .lsu_rvalid_o(lsu_rvalid_o), .lsu_rready_i(lsu_rready_i), .lsu_rdata_o(lsu_rdata_o),
        .lsu_rresp_o(lsu_rresp_o), .lsu_rlast_o(lsu_rlast_o),
        .lsu_awvalid_i(lsu_awvalid_i), .lsu_awready_o(lsu_awready_o), .lsu_awaddr_i(lsu_awaddr_i),
        .lsu_awlen_i(lsu_awlen_i), .lsu_awsize_i(lsu_awsize_i), .lsu_awburst_i(lsu_awburst_i),
        .lsu_wvalid_i(lsu_wvalid_i), .lsu_wready_o(lsu_wready_o), .lsu_wdata_i(lsu_wdata_i),
        .lsu_wstrb_i(lsu_wstrb_i), .lsu_wlast_i(lsu_wlast_i),
        .lsu_bvalid_o(lsu_bvalid_o), .lsu_bready_i(lsu_bready_i), .lsu_bresp_o(lsu_bresp_o),
        .io_master_arvalid(io_master_arvalid), .io_master_arready(io_master_arready),
        .io_master_arid(io_master_arid), .io_master_araddr(io_master_araddr),
        .io_master_arlen(io_master_arlen), .io_master_arsize(io_master_arsize),
        .io_master_arburst(io_master_arburst),
        .io_master_rvalid(io_master_rvalid), .io_master_rready(io_master_rready),
        .io_master_rid(io_master_rid), .io_master_rdata(io_master_rdata),
        .io_master_rresp(io_master_rresp), .io_master_rlast(io_master_rlast),
        .io_master_awvalid(io_master_awvalid), .io_master_awready(io_master_awready),
        .io_master_awid(io_master_awid), .io_master_awaddr(io_master_awaddr),
        .io_master_awlen(io_master_awlen), .io_master_awsize(io_master_awsize),
        .io_master_awburst(io_master_awburst),
        .io_master_wvalid(io_master_wvalid), .io_master_wready(io_master_wready),
        .io_master_wdata(io_master_wdata), .io_master_wstrb(io_master_wstrb),
        .io_master_wlast(io_master_wlast),
        .io_master_bvalid(io_master_bvalid), .io_master_bready(io_master_bready),
        .io_master_bid(io_master_bid), .io_master_bresp(io_master_bresp),
        .burst_err_o(burst_err_o), .rd_state_o(rd_state_o)
    );

    // clock / reset
    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Waits (bounded) for io_master_arvalid, checks the request, then accepts it.
    task automatic ar_accept(input string tag, input logic [3:0] exp_id,
                             input logic [31:0] exp_addr, input logic [7:0] exp_len);
        int waited;
        waited = 0;
        while (io_master_arvalid !== 1'b1 && waited < 30) begin
            tick();
            waited++;
        end
        check({tag, "_arvalid"}, io_master_arvalid, 1);
        if (io_master_arvalid === 1'b1) begin
            check({tag, "_arid"}, io_master_arid, exp_id);
            check({tag, "_araddr"}, io_master_araddr, exp_addr);
            check({tag, "_arlen"}, io_master_arlen, exp_len);
            io_master_arready = 1'b1;
            #1;
            check({tag, "_ifu_arready"}, ifu_arready_o, (exp_id == 4'd0) ? 1 : 0);
            check({tag, "_lsu_arready"}, lsu_arready_o, (exp_id == 4'd1) ? 1 : 0);
            tick();
            io_master_arready = 1'b0;
        end
    endtask

    // Slave drives n beats; rlast on beat last_at. visible=0 expects the beat hidden from IFU.
    task automatic r_beats(input string tag, input bit to_lsu, input int n,
                           input int last_at, input bit visible, input logic [63:0] base);
        for (int i = 0; i < n; i++) begin
            io_master_rvalid = 1'b1;
            io_master_rdata  = base + 64'(i);
            io_master_rresp  = AXI_RESP_OKAY;
            io_master_rlast  = (i == last_at);
            #1;
            check({tag, "_rready"}, io_master_rready, 1);
            if (to_lsu) begin
                check({tag, "_lsu_rvalid"}, lsu_rvalid_o, 1);
                check({tag, "_ifu_rvalid"}, ifu_rvalid_o, 0);
                check({tag, "_lsu_rdata"}, lsu_rdata_o, base + 64'(i));
                check({tag, "_lsu_rlast"}, lsu_rlast_o, (i == last_at) ? 1 : 0);
            end else begin
                check({tag, "_ifu_rvalid"}, ifu_rvalid_o, visible ? 1 : 0);
                check({tag, "_lsu_rvalid"}, lsu_rvalid_o, 0);
                if (visible) begin
                    check({tag, "_ifu_rdata"}, ifu_rdata_o, base + 64'(i));
                    check({tag, "_ifu_rlast"}, ifu_rlast_o, (i == last_at) ? 1 : 0);
                end
            end
            tick();
        end
        io_master_rvalid = 1'b0;
        io_master_rlast  = 1'b0;
    endtask

    initial begin
        reset = 1'b1; ifu_flush_i = 1'b0;
        ifu_arvalid_i = 0; ifu_araddr_i = '0; ifu_arlen_i = '0; ifu_arsize_i = 3'd3;
        ifu_arburst_i = AXI_BURST_INCR; ifu_rready_i = 1'b1;
        lsu_arvalid_i = 0; lsu_araddr_i = '0; lsu_arlen_i = '0; lsu_arsize_i = 3'd3;
        lsu_arburst_i = AXI_BURST_INCR; lsu_rready_i = 1'b1;
        lsu_awvalid_i = 0; lsu_awaddr_i = '0; lsu_awlen_i = '0; lsu_awsize_i = 3'd3;
        lsu_awburst_i = AXI_BURST_INCR; lsu_wvalid_i = 0; lsu_wdata_i = '0; lsu_wstrb_i = '0;
        lsu_wlast_i = 0; lsu_bready_i = 1'b0;
        io_master_arready = 0; io_master_rvalid = 0; io_master_rid = '0; io_master_rdata = '0;
        io_master_rresp = '0; io_master_rlast = 0; io_master_awready = 0; io_master_wready = 0;
        io_master_bvalid = 0; io_master_bid = '0; io_master_bresp = '0;

        repeat (3) tick();
        check("rst_state", rd_state_o, RD_IDLE);
        check("rst_arvalid", io_master_arvalid, 0);
        check("rst_rready", io_master_rready, 0);
        check("rst_ifu_arready", ifu_arready_o, 0);
        check("rst_lsu_rvalid", lsu_rvalid_o, 0);
        check("rst_burst_err", burst_err_o, 0);
        reset = 1'b0;
        tick();

        // IFU alone, len 3
        ifu_arvalid_i = 1'b1; ifu_araddr_i = 32'h8000_0000; ifu_arlen_i = 8'd3;
        tick();
        check("t1_state_ar", rd_state_o, RD_AR_IFU);
        ar_accept("t1", 4'd0, 32'h8000_0000, 8'd3);
        ifu_arvalid_i = 1'b0;
        check("t1_state_r", rd_state_o, RD_R_IFU);
        r_beats("t1", 1'b0, 4, 3, 1'b1, 64'h1111_0000_0000_0000);
        check("t1_idle", rd_state_o, RD_IDLE);

        // Same-cycle tie: LSU wins under fixed priority
        ifu_arvalid_i = 1'b1; ifu_araddr_i = 32'h8000_0100; ifu_arlen_i = 8'd0;
        lsu_arvalid_i = 1'b1; lsu_araddr_i = 32'h2000_0040; lsu_arlen_i = 8'd1;
        tick();
        check("t2_state_ar_lsu", rd_state_o, RD_AR_LSU);
        ar_accept("t2_lsu", 4'd1, 32'h2000_0040, 8'd1);
        lsu_arvalid_i = 1'b0;
        r_beats("t2_lsu", 1'b1, 2, 1, 1'b1, 64'h2222_0000_0000_0000);
        check("t2_idle", rd_state_o, RD_IDLE);
        ar_accept("t2_ifu", 4'd0, 32'h8000_0100, 8'd0);
        ifu_arvalid_i = 1'b0;
        r_beats("t2_ifu", 1'b0, 1, 0, 1'b1, 64'h3333_0000_0000_0000);
        check("t2_idle2", rd_state_o, RD_IDLE);

        // Flush after beat 1 of a len-3 IFU burst; remaining beats are drained
        ifu_arvalid_i = 1'b1; ifu_araddr_i = 32'h8000_0200; ifu_arlen_i = 8'd3;
        ar_accept("t3", 4'd0, 32'h8000_0200, 8'd3);
        ifu_arvalid_i = 1'b0;
        r_beats("t3_b1", 1'b0, 1, 99, 1'b1, 64'h4444_0000_0000_0000);
        ifu_flush_i = 1'b1; ifu_rready_i = 1'b0;
        r_beats("t3_b2", 1'b0, 1, 99, 1'b0, 64'h4444_0000_0000_0001);
        ifu_flush_i = 1'b0;
        r_beats("t3_b34", 1'b0, 2, 1, 1'b0, 64'h4444_0000_0000_0002);
        check("t3_idle", rd_state_o, RD_IDLE);
        check("t3_no_err", burst_err_o, 0);
        ifu_rready_i = 1'b1;
        lsu_arvalid_i = 1'b1; lsu_araddr_i = 32'h2000_0080; lsu_arlen_i = 8'd0;
        ar_accept("t3_lsu", 4'd1, 32'h2000_0080, 8'd0);
        lsu_arvalid_i = 1'b0;
        r_beats("t3_lsu", 1'b1, 1, 0, 1'b1, 64'h5555_0000_0000_0000);

        // Outstanding LSU write blocks an LSU read; IFU read proceeds meanwhile
        lsu_awvalid_i = 1'b1; lsu_awaddr_i = 32'h2000_1000; io_master_awready = 1'b1;
        #1;
        check("t4_awvalid", io_master_awvalid, 1);
        check("t4_awid", io_master_awid, 1);
        check("t4_awaddr", io_master_awaddr, 32'h2000_1000);
        check("t4_awready", lsu_awready_o, 1);
        tick();
        lsu_awvalid_i = 1'b0; io_master_awready = 1'b0;
        lsu_wvalid_i = 1'b1; lsu_wdata_i = 64'hCAFE_F00D_1234_5678; lsu_wstrb_i = 8'hFF;
        lsu_wlast_i = 1'b1; io_master_wready = 1'b1;
        #1;
        check("t4_wdata", io_master_wdata, 64'hCAFE_F00D_1234_5678);
        check("t4_wready", lsu_wready_o, 1);
        lsu_arvalid_i = 1'b1; lsu_araddr_i = 32'h2000_1000; lsu_arlen_i = 8'd0;
        ifu_arvalid_i = 1'b1; ifu_araddr_i = 32'h8000_0300; ifu_arlen_i = 8'd0;
        tick();
        lsu_wvalid_i = 1'b0; lsu_wlast_i = 1'b0; io_master_wready = 1'b0;
        check("t4_state_ifu", rd_state_o, RD_AR_IFU);
        ar_accept("t4_ifu", 4'd0, 32'h8000_0300, 8'd0);
        ifu_arvalid_i = 1'b0;
        r_beats("t4_ifu", 1'b0, 1, 0, 1'b1, 64'h6666_0000_0000_0000);
        for (int i = 0; i < 5; i++) begin
            check("t4_blocked", io_master_arvalid, 0);
            tick();
        end
        lsu_bready_i = 1'b1; io_master_bvalid = 1'b1; io_master_bresp = AXI_RESP_SLVERR;
        #1;
        check("t4_bvalid", lsu_bvalid_o, 1);
        check("t4_bresp", lsu_bresp_o, AXI_RESP_SLVERR);
        check("t4_bready", io_master_bready, 1);
        tick();
        io_master_bvalid = 1'b0; lsu_bready_i = 1'b0; io_master_bresp = AXI_RESP_OKAY;
        check("t4_still_idle", io_master_arvalid, 0);
        ar_accept("t4_lsu", 4'd1, 32'h2000_1000, 8'd0);
        lsu_arvalid_i = 1'b0;
        r_beats("t4_lsu", 1'b1, 1, 0, 1'b1, 64'h7777_0000_0000_0000);

        // Early rlast: beat 2 of len 3
        ifu_arvalid_i = 1'b1; ifu_araddr_i = 32'h8000_0400; ifu_arlen_i = 8'd3;
        ar_accept("t5", 4'd0, 32'h8000_0400, 8'd3);
        ifu_arvalid_i = 1'b0;
        check("t5_err_before", burst_err_o, 0);
        r_beats("t5", 1'b0, 2, 1, 1'b1, 64'h8888_0000_0000_0000);
        check("t5_err", burst_err_o, 1);
        check("t5_idle", rd_state_o, RD_IDLE);
        repeat (3) tick();
        check("t5_err_sticky", burst_err_o, 1);

        // Reset in the middle of an LSU burst
        lsu_arvalid_i = 1'b1; lsu_araddr_i = 32'h2000_2000; lsu_arlen_i = 8'd3;
        ar_accept("t6", 4'd1, 32'h2000_2000, 8'd3);
        lsu_arvalid_i = 1'b0;
        r_beats("t6", 1'b1, 1, 99, 1'b1, 64'h9999_0000_0000_0000);
        check("t6_state_r", rd_state_o, RD_R_LSU);
        reset = 1'b1;
        tick();
        check("t6_state", rd_state_o, RD_IDLE);
        check("t6_arvalid", io_master_arvalid, 0);
        check("t6_rready", io_master_rready, 0);
        check("t6_lsu_rvalid", lsu_rvalid_o, 0);
        check("t6_lsu_arready", lsu_arready_o, 0);
        check("t6_burst_err", burst_err_o, 0);
        reset = 1'b0;
        tick();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/axi4_mem_arbiter.md
Name: axi4_mem_arbiter

Overview:
Shares the core's single AXI4 master port between two requesters.
- Instruction fetch path (icache refill): read-only.
- Load/store unit: read and write.
The arbiter sits between the fetch and LSU stages and the SoC/memory interconnect. It sequences whole read bursts per grant and forwards LSU writes unchanged. Requesters drive standard AXI4 signals; the arbiter alone drives io_master_*.

Parameters:
- ADDR_W, 32, address width (matches AXI4 araddr/awaddr buses)
- DATA_W, 64, data width (matches AXI4 rdata/wdata buses)
- ID_W, 4, AXI ID width
- IFU_ID, 0, ID stamped on IFU reads
- LSU_ID, 1, ID stamped on LSU reads and writes

Ports:
- clock  in  1  system clock
- reset  in  1  synchronous active-high reset
- ifu_flush_i  in  1  fetch flush; marks the current IFU burst as discard-on-return
- ifu_ar{valid_i,ready_o,addr_i,len_i,size_i,burst_i}  mixed  1/1/ADDR_W/8/3/2  IFU read address channel
- ifu_r{valid_o,ready_i,data_o,resp_o,last_o}  mixed  1/1/DATA_W/2/1  IFU read data channel
- lsu_ar{valid_i,ready_o,addr_i,len_i,size_i,burst_i}  mixed  1/1/ADDR_W/8/3/2  LSU read address channel
- lsu_r{valid_o,ready_i,data_o,resp_o,last_o}  mixed  1/1/DATA_W/2/1  LSU read data channel
- lsu_aw{valid_i,ready_o,addr_i,len_i,size_i,burst_i}  mixed  1/1/ADDR_W/8/3/2  LSU write address channel
- lsu_w{valid_i,ready_o,data_i,strb_i,last_i}  mixed  1/1/DATA_W/DATA_W/8/1  LSU write data channel
- lsu_b{valid_o,ready_i,resp_o}  mixed  1/1/2  LSU write response channel
- io_master_ar*/r*/aw*/w*/b*  mixed  AXI4 widths  downstream AXI4 master port (includes id fields)
- burst_err_o  out  1  sticky: rlast disagreed with the beat count; cleared only by reset

Behaviour:
- Reset: read FSM goes to IDLE. All *valid_o, *ready_o, io_master_*valid, io_master_*ready, and burst_err_o are 0. Beat counter is 0 and the round-robin pointer points to IFU.
- Read FSM states: IDLE, AR_IFU, R_IFU, AR_LSU, R_LSU.
- IDLE: pick a winner among asserted ar*valid_i. Move to AR_x on the next cycle.
- AR_x:
  - io_master_arvalid=1 with the winner's fields; arid = x's ID.
  - Winner's ar*ready_o = io_master_arready; the loser's is 0.
  - On handshake: latch len into the beat counter and go to R_x.
- R_x:
  - io_master_r* is routed to x only. io_master_rready = x_rready_i, or 1 if the burst is discarded.
  - The counter decrements on each beat.
  - On a beat with rlast=1: go to IDLE. If the counter was not 0, or a beat arrived with counter 0 and rlast=0, set burst_err_o.
- Grant is never pre-empted mid-burst. The minimum IFU grant-to-arvalid latency is 1 cycle (IDLE->AR_IFU).
- rid/bid are not used for routing (one outstanding read; writes are LSU-only). The ID is still driven.
- Fixed-priority selection (default): LSU wins a same-cycle tie.
- ifu_flush_i while in AR_IFU:
  - Before the handshake: drop arvalid only if the handshake has not occurred, and return to IDLE. Once io_master_arvalid is high it must stay high until handshake (AXI rule), so the flush is recorded instead and the burst is discarded.
  - Discard mode: ifu_r valid_o is forced to 0, and beats are drained with rready=1 until rlast.
- ifu_flush_i in R_IFU: same discard mode for the remaining beats. Flush in IDLE/LSU states: no effect.
- Write path:
  - lsu_aw/lsu_w/lsu_b are wired combinationally to io_master_aw/w/b; awid = LSU_ID.
  - A write and an IFU read may overlap.
  - An LSU read is not granted while an LSU write has aw-accepted-but-b-not-returned. A 1-bit pending flag orders the two: set on AW handshake, cleared on B handshake.
- Reset mid-burst: FSM is forced to IDLE immediately. Downstream is reset by the same reset.

Optional Feature:
- ARB_RR_EN defined:
  - IDLE ties are round-robin. The pointer flips to the other requester after each granted burst completes.
  - Guarantees IFU a grant within one LSU burst.
- ARB_RR_EN undefined: fixed LSU priority; no pointer register.

Decomposition:
- Shared package/defines:
  - FSM state encodings (3-bit)
  - AXI burst/resp constants: INCR, OKAY, SLVERR
  - IFU_ID / LSU_ID defaults
  - Bus-width macros
- One natural sub-module: axi4_rd_mux. Combinational AR/R steering from a grant vector and a discard bit; the FSM and counter stay in the top.

Test Plan:
- IFU alone: arvalid, addr 0x8000_0000, len 3 -> io_master_arid=0; 4 beats routed to ifu_r with last on beat 4; FSM back to IDLE the cycle after rlast.
- Same-cycle IFU+LSU arvalid, fixed priority -> LSU burst first (arid=1), then IFU. With ARB_RR_EN, a second tie -> IFU first.
- ifu_flush_i during R_IFU after beat 1 of len 3 -> ifu_rvalid_o stays 0 for beats 2-4; io_master_rready=1; returns to IDLE; next LSU read is granted.
- LSU write (aw/w accepted, bvalid delayed 10 cycles) plus LSU read request -> io_master_arvalid held 0 until the B handshake, then the read issues; a concurrent IFU read proceeds meanwhile.
- Downstream asserts rlast on beat 2 of len 3 -> burst_err_o=1 and stays 1; FSM returns to IDLE.
- Reset asserted in R_LSU mid-burst -> next cycle all valids/readies are 0, state is IDLE, burst_err_o=0.
